load_store_unit: RTL

//  Downstream consumer of the ALU in the EX->MEM path. It takes ALUResult as the byte address of a RISC-V

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// byte-offset type and the access-legality helper.
package lsu_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_LANES = WORD_W / 8;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef logic [1:0] byte_off_t;

  // True when the size/sign code is legal for the op and the address is
  // naturally aligned for that size. Unsigned variants exist only for loads.
  function automatic logic lsu_access_ok(input logic is_load,
                                         input logic [2:0] f3,
                                         input byte_off_t off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = is_load;
      F3_H:    ok = ~off[0];
      F3_HU:   ok = is_load & ~off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: replicates store data across lanes and
// builds byte enables; selects and sign/zero-extends the loaded byte/half.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]           i_funct3,
  input  byte_off_t            i_off,
  input  logic [WORD_W-1:0]    i_store_data,
  input  logic [WORD_W-1:0]    i_rdata,
  output logic [WORD_W-1:0]    o_wdata,
  output logic [NUM_LANES-1:0] o_be,
  output logic [WORD_W-1:0]    o_load_data
);

  logic [7:0]  w_lane [NUM_LANES];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Split the read word into its byte lanes
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_lane[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[i_off];
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Store path: the memory samples only the enabled lanes, so replicating
  // the datum into every lane makes the offset irrelevant for wdata.
  always_comb begin
    o_wdata = i_store_data;
    o_be    = 4'b1111;
    case (i_funct3)
      F3_B: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_be    = 4'b0001 << i_off;
      end
      F3_H: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_be    = 4'b0011 << i_off;
      end
      default: begin
        o_wdata = i_store_data;
        o_be    = 4'b1111;
      end
    endcase
  end

  // Load path: extend the selected byte/half to a full word
  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit sitting after the ALU: turns an EX-stage load/store into a
// req/gnt/rvalid memory transaction and stalls the pipeline until it retires.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ExValid,
  input  logic                  Flush,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  LoadValid,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic                  MemFault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            r_state;
  logic                  r_req;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;
  byte_off_t             r_off;
  logic                  r_done;
  logic                  r_load_valid;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_fault;

  logic                  w_try;
  logic                  w_legal;
  logic                  w_accept;
  logic                  w_fault;
  logic [DATA_WIDTH-1:0] w_st_wdata;
  logic [3:0]            w_st_be;
  logic [DATA_WIDTH-1:0] w_ld_ext;

  // Store lanes come from the live EX operands; load extraction uses the
  // size/offset captured at accept, since ALUResult has moved on by then.
  lsu_align u_st_align (
    .i_funct3     (Funct3),
    .i_off        (ALUResult[1:0]),
    .i_store_data (StoreData),
    .i_rdata      (mem_rdata),
    .o_wdata      (w_st_wdata),
    .o_be         (w_st_be),
    .o_load_data  ()
  );

  lsu_align u_ld_align (
    .i_funct3     (r_funct3),
    .i_off        (r_off),
    .i_store_data (StoreData),
    .i_rdata      (mem_rdata),
    .o_wdata      (),
    .o_be         (),
    .o_load_data  (w_ld_ext)
  );

  // Accept decode; a simultaneous read+write request is treated as illegal
  assign w_try    = (r_state == IDLE) & ExValid & ~Flush & (MemRead | MemWrite) & ~reset;
  assign w_legal  = ~(MemRead & MemWrite) & lsu_access_ok(MemRead, Funct3, ALUResult[1:0]);
  assign w_accept = w_try & w_legal;
  assign w_fault  = w_try & ~w_legal;

  // Stall covers the accept cycle combinationally, then REQ and WAIT
  assign Stall = w_accept | (r_state == REQ) | (r_state == WAIT);

  assign Done      = r_done;
  assign LoadValid = r_load_valid;
  assign LoadData  = r_load_data;
  assign MemFault  = r_fault;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

  // Transaction FSM with registered memory-port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= 4'b0000;
      r_wdata      <= '0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_done       <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_fault      <= w_fault;
      r_done       <= 1'b0;
      r_load_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req    <= 1'b1;
            r_we     <= MemWrite;
            r_addr   <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
            r_be     <= MemWrite ? w_st_be : 4'b1111;
            r_wdata  <= MemWrite ? w_st_wdata : '0;
            r_funct3 <= Funct3;
            r_off    <= ALUResult[1:0];
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            r_req <= 1'b0;
            if (r_we) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_load_data  <= w_ld_ext;
            r_done       <= 1'b1;
            r_load_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
